// File: rtl/pipe_issue_arbiter_if.sv
// Issue-side bundle between the requesters/control and pipe_issue_arbiter.
// slave is the arbiter's view; master is the driver's (requesters + control) view.
interface pipe_issue_arbiter_if #(
  parameter int unsigned INST_W = 8
);
  logic              enable;
  logic              drain_req;
  logic [INST_W-1:0] req0_inst;
  logic              req0_valid;
  logic              req0_ready;
  logic [INST_W-1:0] req1_inst;
  logic              req1_valid;
  logic              req1_ready;
  logic [INST_W-1:0] inst_out;
  logic              start_out;
  logic              issue_valid;
  logic              issue_src;
  logic              drain_done;
  logic              busy;

  modport master (
    output enable, drain_req, req0_inst, req0_valid, req1_inst, req1_valid,
    input  req0_ready, req1_ready, inst_out, start_out, issue_valid, issue_src,
    input  drain_done, busy
  );

  modport slave (
    input  enable, drain_req, req0_inst, req0_valid, req1_inst, req1_valid,
    output req0_ready, req1_ready, inst_out, start_out, issue_valid, issue_src,
    output drain_done, busy
  );
endinterface

// File: rtl/pipe_issue_arbiter.sv
// Two-requester round-robin issue controller with drain sequencing for the 3-stage core.
// Optional per-source/NOP statistics counters enabled by PIPE_ISSUE_ARB_STATS_EN.
module pipe_issue_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INST_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  pipe_issue_arbiter_if.slave     bus
`ifdef PIPE_ISSUE_ARB_STATS_EN
  ,
  output logic [15:0]             stat_issue0,
  output logic [15:0]             stat_issue1,
  output logic [15:0]             stat_nop
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        r_state, w_state_nxt;
  logic [INST_W-1:0] r_inst;
  logic              r_start, r_issue_valid, r_issue_src, r_drain_done, r_rr;
  logic [1:0]        r_wen_sh;

  logic [INST_W-1:0] r_mem  [2][DEPTH];
  logic [PTR_W-1:0]  r_wptr [2];
  logic [PTR_W-1:0]  r_rptr [2];
  logic [CNT_W-1:0]  r_cnt  [2];

  logic [INST_W-1:0] w_inst [2];
  logic [1:0]        w_valid, w_full, w_nempty, w_ready, w_push, w_pop;
  logic              w_accept, w_grant, w_grant_src;
  logic [INST_W-1:0] w_head;

  function automatic logic is_write(input logic [1:0] op);
    return op != 2'b00;
  endfunction

  assign w_inst[0]  = bus.req0_inst;
  assign w_inst[1]  = bus.req1_inst;
  assign w_valid[0] = bus.req0_valid;
  assign w_valid[1] = bus.req1_valid;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_full[i]   = (r_cnt[i] == FULL_CNT);
      w_nempty[i] = (r_cnt[i] != '0);
      // Readiness ignores same-cycle pops and is forced low while reset is held.
      w_ready[i]  = rst && !w_full[i] && ((r_state == ST_IDLE) || (r_state == ST_RUN));
      w_push[i]   = w_valid[i] && w_ready[i];
    end
    w_accept    = (r_state == ST_RUN) && bus.enable && !bus.drain_req;
    w_grant     = w_accept && (|w_nempty);
    w_grant_src = (&w_nempty) ? r_rr : w_nempty[1];
    w_pop       = '0;
    if (w_grant) w_pop[w_grant_src] = 1'b1;
    w_head      = r_mem[w_grant_src][r_rptr[w_grant_src]];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.enable) w_state_nxt = ST_RUN;
      ST_RUN:   if (bus.drain_req || !bus.enable) w_state_nxt = ST_DRAIN;
      // Wait until nothing in inst_out or the core's EX/WB stages still writes a register.
      ST_DRAIN: if (!is_write(r_inst[INST_W-1 -: 2]) && (r_wen_sh == 2'b00))
                  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_inst        <= '0;
      r_start       <= 1'b0;
      r_issue_valid <= 1'b0;
      r_issue_src   <= 1'b0;
      r_drain_done  <= 1'b0;
      r_rr          <= 1'b0;
      r_wen_sh      <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      r_state       <= w_state_nxt;
      r_start       <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_inst        <= w_grant ? w_head : '0;
      r_issue_valid <= w_grant;
      r_drain_done  <= (w_state_nxt == ST_DONE);
      if (w_grant) begin
        r_issue_src <= w_grant_src;
        r_rr        <= ~w_grant_src;
      end
      if (r_start) r_wen_sh <= {is_write(r_inst[INST_W-1 -: 2]), r_wen_sh[1]};
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PTR_W'(1);
        r_cnt[i] <= r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= w_inst[i];
    end
  end

  assign bus.req0_ready  = w_ready[0];
  assign bus.req1_ready  = w_ready[1];
  assign bus.inst_out    = r_inst;
  assign bus.start_out   = r_start;
  assign bus.issue_valid = r_issue_valid;
  assign bus.issue_src   = r_issue_src;
  assign bus.drain_done  = r_drain_done;
  assign bus.busy        = (r_state != ST_IDLE);

`ifdef PIPE_ISSUE_ARB_STATS_EN
  logic [15:0] r_stat_issue0, r_stat_issue1, r_stat_nop;

  // Counts reflect cycles already presented to the core (registered outputs).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_issue0 <= '0;
      r_stat_issue1 <= '0;
      r_stat_nop    <= '0;
    end else if (r_state == ST_DONE) begin
      r_stat_issue0 <= '0;
      r_stat_issue1 <= '0;
      r_stat_nop    <= '0;
    end else begin
      if (r_issue_valid && !r_issue_src && (r_stat_issue0 != 16'hFFFF))
        r_stat_issue0 <= r_stat_issue0 + 16'd1;
      if (r_issue_valid && r_issue_src && (r_stat_issue1 != 16'hFFFF))
        r_stat_issue1 <= r_stat_issue1 + 16'd1;
      if (r_start && !r_issue_valid && (r_stat_nop != 16'hFFFF))
        r_stat_nop <= r_stat_nop + 16'd1;
    end
  end

  assign stat_issue0 = r_stat_issue0;
  assign stat_issue1 = r_stat_issue1;
  assign stat_nop    = r_stat_nop;
`endif

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Directed self-checking bench for pipe_issue_arbiter (DEPTH=4, INST_W=8).
// Covers reset, backpressure, round-robin, single issue, drain timing and mid-run reset.
module tb_pipe_issue_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipe_issue_arbiter_if #(.INST_W(8)) bus ();

`ifdef PIPE_ISSUE_ARB_STATS_EN
  logic [15:0] stat_issue0, stat_issue1, stat_nop;
`endif

  pipe_issue_arbiter #(
    .DEPTH  (4),
    .INST_W (8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef PIPE_ISSUE_ARB_STATS_EN
    ,
    .stat_issue0 (stat_issue0),
    .stat_issue1 (stat_issue1),
    .stat_nop    (stat_nop)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !bus.drain_done; i++) step();
    check("drain_done_seen", bus.drain_done, 1);
  endtask

  logic [7:0] q0 [3];
  logic [7:0] q1 [4];
  logic [7:0] rr_exp [6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.enable     = 1'b0;
    bus.drain_req  = 1'b0;
    bus.req0_inst  = '0;
    bus.req0_valid = 1'b0;
    bus.req1_inst  = '0;
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    check("rst_inst", bus.inst_out, 0);
    check("rst_start", bus.start_out, 0);
    check("rst_ivalid", bus.issue_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("idle_ready0", bus.req0_ready, 1);

    // Backpressure: fill requester 1 while idle.
    q1[0] = 8'hC1; q1[1] = 8'h82; q1[2] = 8'h43; q1[3] = 8'hD7;
    for (int k = 0; k < 4; k++) begin
      bus.req1_valid = 1'b1;
      bus.req1_inst  = q1[k];
      check("bp_ready_open", bus.req1_ready, 1);
      step();
    end
    check("bp_ready_full", bus.req1_ready, 0);
    bus.req1_inst = 8'hEE;
    step();
    step();
    bus.req1_valid = 1'b0;
    bus.enable = 1'b1;
    step();
    check("run_start", bus.start_out, 1);
    check("run_first_nop", bus.inst_out, 0);
    check("bp_still_full", bus.req1_ready, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_pop_inst", bus.inst_out, q1[k]);
      check("bp_pop_src", bus.issue_src, 1);
      check("bp_pop_valid", bus.issue_valid, 1);
      if (k == 0) check("bp_ready_reopen", bus.req1_ready, 1);
    end
    step();
    check("bp_held_not_taken", bus.inst_out, 0);
    check("bp_empty_ivalid", bus.issue_valid, 0);

    // Drain to idle, then preload both FIFOs for round-robin.
    bus.enable = 1'b0;
    wait_done(12);
    check("done_start_low", bus.start_out, 0);
    step();
    check("idle_after_done", bus.busy, 0);
    q0[0] = 8'h45; q0[1] = 8'h9A; q0[2] = 8'hE3;
    rr_exp = '{8'h45, 8'h67, 8'h9A, 8'hB8, 8'hE3, 8'h2C};
    for (int k = 0; k < 3; k++) begin
      bus.req0_valid = 1'b1;
      bus.req0_inst  = q0[k];
      bus.req1_valid = 1'b1;
      bus.req1_inst  = rr_exp[2*k+1];
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.enable = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_inst", bus.inst_out, rr_exp[k]);
      check("rr_src", bus.issue_src, k % 2);
      check("rr_valid", bus.issue_valid, 1);
    end
    step();
    check("rr_tail_nop", bus.inst_out, 0);

    // Single requester, no bypass.
    bus.req0_valid = 1'b1;
    bus.req0_inst  = 8'h56;
    step();
    bus.req0_valid = 1'b0;
    check("single_no_bypass", bus.inst_out, 0);
    step();
    check("single_inst", bus.inst_out, 8'h56);
    check("single_valid", bus.issue_valid, 1);
    check("single_src", bus.issue_src, 0);
    step();
    check("single_after", bus.inst_out, 0);
    check("single_after_valid", bus.issue_valid, 0);

    // Drain right after a write: three NOP cycles, then one done cycle.
    bus.req0_valid = 1'b1;
    bus.req0_inst  = 8'h4E;
    step();
    bus.req0_valid = 1'b0;
    step();
    check("dw_issue", bus.inst_out, 8'h4E);
    bus.drain_req = 1'b1;
    step();
    bus.drain_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("dw_nop_inst", bus.inst_out, 0);
      check("dw_nop_start", bus.start_out, 1);
      check("dw_nop_notdone", bus.drain_done, 0);
      step();
    end
    check("dw_done", bus.drain_done, 1);
    check("dw_done_start", bus.start_out, 0);
    step();
    check("dw_done_pulse", bus.drain_done, 0);
    check("dw_idle", bus.busy, 0);
    step();
    check("dw_rerun", bus.busy, 1);
    check("dw_rerun_start", bus.start_out, 1);

    // Reset mid-run with entries queued.
    for (int k = 0; k < 2; k++) begin
      bus.req0_valid = 1'b1;
      bus.req0_inst  = 8'h11 + 8'(k);
      bus.req1_valid = 1'b1;
      bus.req1_inst  = 8'h21 + 8'(k);
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.enable = 1'b0;
    rst = 1'b0;
    #1;
    check("mr_inst", bus.inst_out, 0);
    check("mr_start", bus.start_out, 0);
    check("mr_ivalid", bus.issue_valid, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_ready0", bus.req0_ready, 0);
    step();
    rst = 1'b1;
    bus.enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mr_post_inst", bus.inst_out, 0);
      check("mr_post_ivalid", bus.issue_valid, 0);
    end

`ifdef PIPE_ISSUE_ARB_STATS_EN
    bus.enable = 1'b0;
    wait_done(12);
    step();
    for (int k = 0; k < 4; k++) begin
      bus.req0_valid = 1'b1;
      bus.req0_inst  = 8'h40 + 8'(k);
      bus.req1_valid = (k < 2);
      bus.req1_inst  = 8'h80 + 8'(k);
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.enable = 1'b1;
    // Cycle 0 is the entry NOP, 1..6 issue, 7..9 NOP; counters seen in cycle 10.
    for (int k = 0; k < 11; k++) step();
    check("st_issue0", stat_issue0, 4);
    check("st_issue1", stat_issue1, 2);
    check("st_nop", stat_nop, 4);
    bus.enable = 1'b0;
    wait_done(12);
    step();
    check("st_clr_issue0", stat_issue0, 0);
    check("st_clr_issue1", stat_issue1, 0);
    check("st_clr_nop", stat_nop, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
